seg_scan_capture: RTL

//  Receive end of the 4-digit multiplexed 7-segment bus (one-hot digit drains + 8 segment lines).

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg7_to_nibble.sv | 23 ++
 rtl/seg_scan_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display bus.
// The segment table is the same one the display driver encodes with,
// so a loopback capture decodes exactly what the driver produced.
package seg_pkg;

  // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One-hot drain selects; index n drives data[4n+3:4n].
  localparam logic [3:0] DIG_SEL [0:3] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Scan FSM states. The ST_ prefix keeps them apart from the SETTLE parameter.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // True when exactly one digit drain is active.
  function automatic logic is_one_hot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  // Slot index for a one-hot drain value; 0 for anything else.
  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel == DIG_SEL[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Inverse of the hex segment encoder: maps a 7-bit segment pattern back to
// its nibble. Patterns outside the table report hit=0 and nibble=0.
module seg7_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  // Search the shared table; at most one entry can match since codes are unique.
  always_comb begin
    hit    = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-segment bus. Each digit is
// sampled once per visit after its drain and segment lines have been stable
// for SETTLE cycles; a complete set of four digits is published as one word.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  drains,
  input  logic [7:0]  leds,
  output logic [15:0] data,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  logic [3:0]           drains_meta, drains_sync, drains_prev;
  logic [7:0]           leds_meta, leds_sync, leds_prev;
  scan_state_e          state;
  logic [CNT_W-1:0]     settle_cnt;
  logic [15:0]          slot_word;
  logic [3:0]           slot_err;
  logic [3:0]           mask;
  logic [3:0]           mask_next;
  logic [TIMEOUT_W-1:0] idle_cnt;

  logic       sync_one_hot;
  logic       drains_changed;
  logic       any_changed;
  logic       do_sample;
  logic       frame_done;
  logic       idle_expired;
  logic [1:0] sample_idx;
  logic       dec_hit;
  logic [3:0] dec_nibble;

  seg7_to_nibble u_decode (
    .seg    (leds_sync[6:0]),
    .hit    (dec_hit),
    .nibble (dec_nibble)
  );

  // Sampling and frame bookkeeping conditions; a sample landing in a clearing
  // cycle keeps its own mask bit so it counts toward the next frame.
  always_comb begin
    sync_one_hot   = is_one_hot(drains_sync);
    drains_changed = (drains_sync != drains_prev);
    any_changed    = drains_changed || (leds_sync != leds_prev);
    do_sample      = (state == ST_SETTLE) && !any_changed && (settle_cnt == SETTLE_CNT);
    frame_done     = (mask == 4'hF);
    idle_expired   = &idle_cnt;
    sample_idx     = sel_index(drains_sync);
    mask_next      = (frame_done || idle_expired) ? 4'd0 : mask;
    if (do_sample) mask_next = mask_next | DIG_SEL[sample_idx];
  end

  // Two-flop synchroniser for the asynchronous pins plus a one-cycle history for change detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drains_meta <= 4'd0;
      drains_sync <= 4'd0;
      drains_prev <= 4'd0;
      leds_meta   <= 8'd0;
      leds_sync   <= 8'd0;
      leds_prev   <= 8'd0;
    end else begin
      drains_meta <= drains;
      drains_sync <= drains_meta;
      drains_prev <= drains_sync;
      leds_meta   <= leds;
      leds_sync   <= leds_meta;
      leds_prev   <= leds_sync;
    end
  end

  // Scan FSM: wait for one drain, count stable cycles, then hold until the drain moves on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_one_hot) begin
            state      <= ST_SETTLE;
            settle_cnt <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (any_changed) begin
            if (sync_one_hot) settle_cnt <= CNT_W'(1);
            else              state      <= ST_IDLE;
          end else if (settle_cnt == SETTLE_CNT) begin
            state <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (drains_changed) begin
            if (sync_one_hot) begin
              state      <= ST_SETTLE;
              settle_cnt <= CNT_W'(1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit slots, per-digit decode errors and the mask of digits seen in this frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_word <= 16'd0;
      slot_err  <= 4'd0;
      mask      <= 4'd0;
    end else begin
      if (do_sample) begin
        slot_word[{sample_idx, 2'b00} +: 4] <= dec_nibble;
        slot_err[sample_idx]                <= ~dec_hit;
      end
      mask <= mask_next;
    end
  end

  // Publish a complete frame; an expired idle timer flags stale unless a frame lands that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data  <= 16'd0;
      valid <= 1'b0;
      err   <= 1'b0;
      stale <= 1'b0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        data  <= slot_word;
        err   <= |slot_err;
        stale <= 1'b0;
      end else if (idle_expired) begin
        stale <= 1'b1;
      end
    end
  end

  // Idle timer restarts on every sample and saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (do_sample) begin
      idle_cnt <= '0;
    end else if (!idle_expired) begin
      idle_cnt <= idle_cnt + TIMEOUT_W'(1);
    end
  end

endmodule
